// File: rtl/awg_pkg.sv
// Shared AWG constants: packer state encoding and default sizing.
package awg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned LP_DATA_WIDE_DEF = 8;
    localparam int unsigned LP_LANES_DEF     = 4;
    localparam int unsigned LP_UFLOW_W_DEF   = 16;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready stream; master = packer view.
interface fifo_rd_packer_if
    import awg_pkg::*;
#(
    parameter int P_DATA_WIDE = LP_DATA_WIDE_DEF,
    parameter int P_LANES     = LP_LANES_DEF
);
    logic                           fifo_empty;
    logic [P_DATA_WIDE-1:0]         fifo_dout;
    logic                           fifo_rd_en;
    logic                           m_valid;
    logic                           m_ready;
    logic [P_DATA_WIDE*P_LANES-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_packer_oreg.sv
// Packed-word output register; a new load wins over clearing on accept.
module fifo_rd_packer_oreg
    import awg_pkg::*;
#(
    parameter int P_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic [P_W-1:0] i_data,
    input  logic           i_ready,
    output logic           o_valid,
    output logic [P_W-1:0] o_data
);
    logic           r_valid;
    logic [P_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/fifo_rd_packer.sv
// Packs P_LANES FIFO samples (lane 0 oldest, at LSBs) into one output word.
// Underflow counting is built only when FIFO_RD_PACKER_UFLOW_EN is defined.
module fifo_rd_packer
    import awg_pkg::*;
#(
    parameter int P_DATA_WIDE = LP_DATA_WIDE_DEF,
    parameter int P_LANES     = LP_LANES_DEF,
    parameter int P_UFLOW_W   = LP_UFLOW_W_DEF
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 i_en,
    fifo_rd_packer_if.master     bus,
    output logic                 o_busy,
    output logic [P_UFLOW_W-1:0] o_uflow_cnt,
    output logic                 o_uflow_flag
);
    // state    | meaning
    // ST_IDLE  | no pops; waits for en
    // ST_RUN   | pops samples into the accumulator, loads full words
    // ST_DRAIN | no pops; flushes the zero-padded partial word, then IDLE

    localparam int LW = $clog2(P_LANES);

    state_t                               r_state, w_state_nxt;
    logic [LW-1:0]                        r_lane_cnt, w_lane_nxt;
    logic [P_LANES-1:0][P_DATA_WIDE-1:0]  r_acc, w_fill;
    logic [P_DATA_WIDE*P_LANES-1:0]       w_load_data;
    logic                                 w_last, w_slot_ok, w_pop, w_load;

    assign w_last    = (r_lane_cnt == LW'(P_LANES-1));
    assign w_slot_ok = !w_last || !bus.m_valid || bus.m_ready;
    // A reset cycle must not consume a sample the FIFO would then lose.
    assign w_pop     = !rst && (r_state == ST_RUN) && !bus.fifo_empty && w_slot_ok;
    assign bus.fifo_rd_en = w_pop;
    assign o_busy    = (r_state != ST_IDLE);
    assign w_load_data = w_fill;

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane_cnt;
        w_fill      = r_acc;
        w_load      = 1'b0;
        if (w_pop) begin
            w_fill[r_lane_cnt] = bus.fifo_dout;
            w_lane_nxt         = w_last ? '0 : r_lane_cnt + LW'(1);
            w_load             = w_last;
        end
        case (r_state)
            ST_IDLE: if (i_en) w_state_nxt = ST_RUN;
            // Decide on the post-pop lane count so a word completed this cycle is not redrained.
            ST_RUN: if (!i_en) w_state_nxt = (w_lane_nxt == '0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.m_valid || bus.m_ready) begin
                    for (int i = 0; i < P_LANES; i++) begin
                        if (i >= int'(r_lane_cnt)) w_fill[i] = '0;
                    end
                    w_load      = 1'b1;
                    w_lane_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lane_cnt <= '0;
            r_acc      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_cnt <= w_lane_nxt;
            r_acc      <= w_fill;
        end
    end

    fifo_rd_packer_oreg #(.P_W(P_DATA_WIDE*P_LANES)) u_oreg (
        .clk     (rd_clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (bus.m_ready),
        .o_valid (bus.m_valid),
        .o_data  (bus.m_data)
    );

`ifdef FIFO_RD_PACKER_UFLOW_EN
    logic                 r_primed;
    logic [P_UFLOW_W-1:0] r_uflow_cnt;
    logic                 r_uflow_flag;
    logic                 w_uflow;

    assign w_uflow = (r_state == ST_RUN) && r_primed && bus.m_ready && !bus.m_valid;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_primed     <= 1'b0;
            r_uflow_cnt  <= '0;
            r_uflow_flag <= 1'b0;
        end else begin
            if (w_state_nxt == ST_IDLE && r_state != ST_IDLE) r_primed <= 1'b0;
            else if (w_load)                                   r_primed <= 1'b1;
            if (w_uflow) begin
                r_uflow_flag <= 1'b1;
                if (r_uflow_cnt != '1) r_uflow_cnt <= r_uflow_cnt + P_UFLOW_W'(1);
            end
        end
    end

    assign o_uflow_cnt  = r_uflow_cnt;
    assign o_uflow_flag = r_uflow_flag;
`else
    assign o_uflow_cnt  = '0;
    assign o_uflow_flag = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: queue-based FIFO and word-packing model.
module tb_fifo_rd_packer;
    import awg_pkg::*;

    logic        rd_clk = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b0;
    logic        busy;
    logic [15:0] uflow_cnt;
    logic        uflow_flag;

    fifo_rd_packer_if #(.P_DATA_WIDE(8), .P_LANES(4)) ifc ();

    fifo_rd_packer #(.P_DATA_WIDE(8), .P_LANES(4), .P_UFLOW_W(16)) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .i_en         (en),
        .bus          (ifc.master),
        .o_busy       (busy),
        .o_uflow_cnt  (uflow_cnt),
        .o_uflow_flag (uflow_flag)
    );

    always #5 rd_clk = ~rd_clk;

    int          n_pass = 0;
    int          n_chk  = 0;
    logic [7:0]  fq[$];
    logic [31:0] got[$];
    bit          gate = 1'b0;
    int          cyc = 0;
    int          viol = 0;
    int          last_pop = -1;
    int          first_valid = -1;
    int          valid_cycles = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic drive_fifo();
        ifc.fifo_empty = gate || (fq.size() == 0);
        ifc.fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // One clock: inputs settle before the falling edge, outputs sampled there.
    task automatic step();
        logic        p, x;
        logic [31:0] d;
        drive_fifo();
        @(negedge rd_clk);
        p = ifc.fifo_rd_en;
        x = ifc.m_valid & ifc.m_ready;
        d = ifc.m_data;
        if (p && ifc.fifo_empty) viol++;
        if (prev_hold && ifc.m_valid && d !== prev_data) viol++;
        prev_hold = ifc.m_valid & !ifc.m_ready;
        prev_data = d;
        if (ifc.m_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (p) last_pop = cyc;
        @(posedge rd_clk);
        #1;
        cyc++;
        if (p) void'(fq.pop_front());
        if (x) got.push_back(d);
    endtask

    task automatic do_reset();
        fq.delete();
        gate = 1'b0;
        en   = 1'b0;
        ifc.m_ready = 1'b0;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
        got.delete();
        viol = 0;
        last_pop = -1;
        first_valid = -1;
        valid_cycles = 0;
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic test_reset();
        do_reset();
        n_chk++; if (ifc.m_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", ifc.m_valid); else n_pass++;
        n_chk++; if (ifc.m_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", ifc.m_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_chk++; if (uflow_cnt !== 16'h0) $display("FAIL reset_uflow_cnt got=%0d exp=0", uflow_cnt); else n_pass++;
        n_chk++; if (uflow_flag !== 1'b0) $display("FAIL reset_uflow_flag got=%0b exp=0", uflow_flag); else n_pass++;
        n_chk++; if (ifc.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%0b exp=0", ifc.fifo_rd_en); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
        repeat (16) step();
        n_chk++; if (got.size() != 1) $display("FAIL basic_count got=%0d exp=1", got.size()); else n_pass++;
        n_chk++; if (got[0] !== 32'h04030201) $display("FAIL basic_data got=%h exp=04030201", got[0]); else n_pass++;
        n_chk++; if (valid_cycles != 1) $display("FAIL basic_valid_len got=%0d exp=1", valid_cycles); else n_pass++;
        n_chk++; if (first_valid - last_pop != 1) $display("FAIL basic_latency got=%0d exp=1", first_valid - last_pop); else n_pass++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        repeat (20) step();
        n_chk++; if (fq.size() != 1) $display("FAIL bp_left got=%0d exp=1", fq.size()); else n_pass++;
        n_chk++; if (ifc.m_data !== 32'h04030201) $display("FAIL bp_held got=%h exp=04030201", ifc.m_data); else n_pass++;
        n_chk++; if (dut.r_lane_cnt !== 2'd3) $display("FAIL bp_lane got=%0d exp=3", dut.r_lane_cnt); else n_pass++;
        n_chk++; if (got.size() != 0) $display("FAIL bp_no_xfer got=%0d exp=0", got.size()); else n_pass++;
        ifc.m_ready = 1'b1;
        repeat (10) step();
        n_chk++; if (got.size() != 2) $display("FAIL bp_count got=%0d exp=2", got.size()); else n_pass++;
        n_chk++; if (got[0] !== 32'h04030201) $display("FAIL bp_word0 got=%h exp=04030201", got[0]); else n_pass++;
        n_chk++; if (got[1] !== 32'h08070605) $display("FAIL bp_word1 got=%h exp=08070605", got[1]); else n_pass++;
        n_chk++; if (viol != 0) $display("FAIL bp_protocol got=%0d exp=0", viol); else n_pass++;
    endtask

    task automatic test_empty_gaps();
        do_reset();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'h0A + 8'(i));
        gate = 1'b1;
        repeat (24) begin
            gate = !gate;
            step();
        end
        gate = 1'b0;
        n_chk++; if (got.size() != 1) $display("FAIL gaps_count got=%0d exp=1", got.size()); else n_pass++;
        n_chk++; if (got[0] !== 32'h0D0C0B0A) $display("FAIL gaps_data got=%h exp=0D0C0B0A", got[0]); else n_pass++;
        n_chk++; if (viol != 0) $display("FAIL gaps_pop_when_empty got=%0d exp=0", viol); else n_pass++;
    endtask

    task automatic test_drain();
        do_reset();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        for (int i = 0; i < 20 && fq.size() != 0; i++) step();
        n_chk++; if (fq.size() != 0) $display("FAIL drain_pops got=%0d exp=0 left", fq.size()); else n_pass++;
        en = 1'b0;
        step();
        n_chk++; if (dut.r_state !== ST_DRAIN) $display("FAIL drain_state got=%0d exp=%0d", dut.r_state, ST_DRAIN); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL drain_busy got=%0b exp=1", busy); else n_pass++;
        step();
        n_chk++; if (ifc.m_valid !== 1'b1) $display("FAIL drain_valid got=%0b exp=1", ifc.m_valid); else n_pass++;
        n_chk++; if (ifc.m_data !== 32'h00002211) $display("FAIL drain_data got=%h exp=00002211", ifc.m_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL drain_idle_busy got=%0b exp=0", busy); else n_pass++;
    endtask

    task automatic test_reset_midword();
        do_reset();
        en = 1'b1;
        ifc.m_ready = 1'b1;
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
        for (int i = 0; i < 20 && fq.size() != 0; i++) step();
        for (int i = 0; i < 4; i++) fq.push_back(8'h31 + 8'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        got.delete();
        n_chk++; if (ifc.m_valid !== 1'b0) $display("FAIL rstmid_valid got=%0b exp=0", ifc.m_valid); else n_pass++;
        n_chk++; if (dut.r_lane_cnt !== 2'd0) $display("FAIL rstmid_lane got=%0d exp=0", dut.r_lane_cnt); else n_pass++;
        n_chk++; if (fq.size() != 4) $display("FAIL rstmid_no_pop got=%0d exp=4", fq.size()); else n_pass++;
        repeat (20) step();
        n_chk++; if (got.size() != 1) $display("FAIL rstmid_count got=%0d exp=1", got.size()); else n_pass++;
        n_chk++; if (got[0] !== 32'h34333231) $display("FAIL rstmid_data got=%h exp=34333231", got[0]); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0]  s[64];
        logic [31:0] exp_w[$];
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s[i] = 8'($urandom);
            fq.push_back(s[i]);
        end
        for (int k = 0; k < 16; k++) exp_w.push_back(pack4(s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]));
        for (int i = 0; i < 2000 && got.size() < 16; i++) begin
            gate = ($urandom_range(0, 3) == 0);
            ifc.m_ready = 1'($urandom_range(0, 1));
            step();
        end
        gate = 1'b0;
        n_chk++; if (got.size() != 16) $display("FAIL rand_count got=%0d exp=16", got.size()); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (got[k] !== exp_w[k]) $display("FAIL rand_word%0d got=%h exp=%h", k, got[k], exp_w[k]);
            else n_pass++;
        end
        n_chk++; if (viol != 0) $display("FAIL rand_protocol got=%0d exp=0", viol); else n_pass++;
    endtask

    task automatic test_underflow();
        logic [15:0] exp_cnt;
        logic        exp_flag;
`ifdef FIFO_RD_PACKER_UFLOW_EN
        exp_cnt  = 16'd5;
        exp_flag = 1'b1;
`else
        exp_cnt  = 16'd0;
        exp_flag = 1'b0;
`endif
        do_reset();
        en = 1'b1;
        for (int i = 5; i <= 8; i++) fq.push_back(8'(i));
        for (int i = 0; i < 20 && ifc.m_valid !== 1'b1; i++) step();
        n_chk++; if (ifc.m_valid !== 1'b1) $display("FAIL uflow_word_ready got=%0b exp=1", ifc.m_valid); else n_pass++;
        ifc.m_ready = 1'b1;
        step();
        repeat (5) step();
        ifc.m_ready = 1'b0;
        n_chk++; if (got.size() != 1 || got[0] !== 32'h08070605) $display("FAIL uflow_word got=%h exp=08070605", got[0]); else n_pass++;
        n_chk++; if (uflow_cnt !== exp_cnt) $display("FAIL uflow_cnt got=%0d exp=%0d", uflow_cnt, exp_cnt); else n_pass++;
        n_chk++; if (uflow_flag !== exp_flag) $display("FAIL uflow_flag got=%0b exp=%0b", uflow_flag, exp_flag); else n_pass++;
    endtask

    initial begin
        ifc.fifo_empty = 1'b1;
        ifc.fifo_dout  = 8'h00;
        ifc.m_ready    = 1'b0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_empty_gaps();
        test_drain();
        test_reset_midword();
        test_random();
        test_underflow();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
